bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 14, giving the binary input width.
REQ-002 The block SHALL have parameter MAX_VAL, default 9999, giving the largest displayable value.
REQ-003 Port clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 Port reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port start  input  1  requests a conversion of bin.
REQ-006 Port bin  input  WIDTH  is the unsigned binary value, sampled only when a start is accepted.
REQ-007 Port busy  output  1  is high while a conversion is in progress.
REQ-008 Port done  output  1  is a one-cycle pulse marking new results.
REQ-009 Ports num3, num2, num1, num0  output  4 each  are BCD digits (thousands..units) feeding displayMux.
REQ-010 Port overflow  output  1  is high when the last accepted bin exceeded MAX_VAL.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 SHALL be accepted at the rising edge: load shift register with min(bin, MAX_VAL), capture overflow flag internally, clear shift counter, go to SHIFT.
REQ-013 In SHIFT, each edge SHALL perform one double-dabble step: add 3 to each BCD nibble >=5, then shift left one bit from the binary field.
REQ-014 SHIFT SHALL last exactly WIDTH cycles, counted by a ceil(log2(WIDTH+1))-bit counter, then go to DONE.
REQ-015 On the SHIFT->DONE edge, num3..num0 and overflow SHALL be updated from the shift register and internal flag.
REQ-016 done SHALL be 1 only while in DONE; DONE SHALL last one cycle, then go to IDLE.
REQ-017 With edge 0 accepting start, done SHALL be high for exactly the cycle after edge WIDTH+1 (edge 15 at default).
REQ-018 busy SHALL be 1 whenever state is not IDLE, combinationally from state.
REQ-019 start while busy=1 (SHIFT or DONE) SHALL be ignored; start held high re-triggers on the first IDLE cycle.
REQ-020 bin changes after acceptance SHALL NOT affect the conversion in progress.
REQ-021 num3..num0 and overflow SHALL hold their last value between done pulses and never show intermediate shift data.
REQ-022 Values above MAX_VAL SHALL saturate to MAX_VAL digits (9,9,9,9) with overflow=1; otherwise overflow=0.
REQ-023 Every output digit SHALL be in range 0..9 at all times.

Reset
REQ-024 reset_n=0 SHALL immediately force state IDLE, counter 0, shift register 0, internal overflow flag 0.
REQ-025 During reset, busy=0, done=0, num3..num0=0, overflow=0.
REQ-026 Reset asserted mid-conversion SHALL abort it; no done pulse follows, and outputs read 0.
REQ-027 After reset release, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-028 A shared package display_pkg SHALL hold typedef bcd_t (4-bit), the state enum (IDLE, SHIFT, DONE) and constant MAX_DISPLAY=9999.
REQ-029 The per-nibble add-3 correction SHALL be a combinational sub-module bcd_digit_adj, instantiated four times.
REQ-030 The top SHALL contain only the FSM, counter, shift register and output registers.

Verification
REQ-031 Reset, then start with bin=0 -> done at edge 15, digits 0,0,0,0, overflow=0.
REQ-032 start with bin=1234 -> busy high edges 0..15, done single cycle after edge 15, digits 1,2,3,4.
REQ-033 bin=9999 -> 9,9,9,9 overflow=0; bin=12000 -> 9,9,9,9 overflow=1; next bin=5 -> 0,0,0,5 overflow=0.
REQ-034 Accept bin=42, pulse start with bin=777 at edge 5 -> ignored, result 0,0,4,2, exactly one done.
REQ-035 After result 0,0,4,2, assert reset_n low at edge 7 of a new conversion -> outputs 0, busy 0, no done; release and convert 808 -> 0,8,0,8.
REQ-036 Hold start high continuously with bin=321 -> done pulses every 17 cycles, digits 0,3,2,1 each time.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package display_pkg;

  // One packed BCD digit, 0..9 when valid.
  typedef logic [3:0] bcd_t;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest value four BCD digits can show.
  localparam int MAX_DISPLAY = 9999;

  // Number of BCD digits driven towards the display mux.
  localparam int BCD_DIGITS = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: adds 3 to a BCD digit of 5 or more.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   i_digit  BCD nibble taken from the shift register before the shift
//   o_digit  corrected nibble, ready to be shifted left by one bit
module bcd_digit_adj
  import display_pkg::*;
(
  input  bcd_t i_digit,
  output bcd_t o_digit
);

  // A digit >= 5 would become >= 10 after doubling; pre-adding 3 makes
  // the shift carry into the next digit instead.
  assign o_digit = (i_digit >= 4'd5) ? bcd_t'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter from unsigned binary to four BCD digits.
// Latency: start accepted at edge 0, done high for the cycle after edge WIDTH+1.
// Backpressure: start is ignored while busy; a held start retriggers from IDLE.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   start, bin            conversion request and value, sampled when accepted
//   busy                  high whenever a conversion is in flight
//   done                  one-cycle pulse when num3..num0/overflow refresh
//   num3..num0            thousands..units digits, held between done pulses
//   overflow              last accepted value exceeded MAX_VAL (saturated)
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = MAX_DISPLAY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output bcd_t             num3,
  output bcd_t             num2,
  output bcd_t             num1,
  output bcd_t             num0,
  output logic             overflow
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam int               BCD_W    = 4 * BCD_DIGITS;
  localparam int               SR_W     = BCD_W + WIDTH;
  localparam logic [WIDTH-1:0] MAX_BIN  = WIDTH'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  // {BCD field (thousands..units), binary field}
  logic [SR_W-1:0]  r_sr;
  logic             r_ovf_int;
  bcd_t             r_num3;
  bcd_t             r_num2;
  bcd_t             r_num1;
  bcd_t             r_num0;
  logic             r_overflow;

  logic             w_ovf;
  logic [WIDTH-1:0] w_sat;
  logic [SR_W-1:0]  w_adj;

  // Saturate before loading so only displayable values get converted.
  assign w_ovf = (bin > MAX_BIN);
  assign w_sat = w_ovf ? MAX_BIN : bin;

  // Correct every BCD nibble in parallel; the binary field passes through.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_sr[WIDTH + 4*gi +: 4]),
      .o_digit (w_adj[WIDTH + 4*gi +: 4])
    );
  end
  assign w_adj[WIDTH-1:0] = r_sr[WIDTH-1:0];

  // One extra SHIFT cycle after the WIDTH-th step copies the finished BCD
  // field to the output registers, so results never show partial data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_ovf_int  <= 1'b0;
      r_num3     <= '0;
      r_num2     <= '0;
      r_num1     <= '0;
      r_num0     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr      <= {{BCD_W{1'b0}}, w_sat};
            r_ovf_int <= w_ovf;
            r_cnt     <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt == LAST_CNT) begin
            r_num3     <= r_sr[WIDTH + 12 +: 4];
            r_num2     <= r_sr[WIDTH + 8  +: 4];
            r_num1     <= r_sr[WIDTH + 4  +: 4];
            r_num0     <= r_sr[WIDTH      +: 4];
            r_overflow <= r_ovf_int;
            r_state    <= DONE;
          end else begin
            r_sr  <= {w_adj[SR_W-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign num3     = r_num3;
  assign num2     = r_num2;
  assign num1     = r_num1;
  assign num0     = r_num0;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against an arithmetic reference.
// Latency: expects done on edge 15 after the accepting edge 0.
// Backpressure: exercises ignored starts, held starts and mid-run reset.
module tb_bin_to_bcd_seq;

  localparam int W    = 14;
  localparam int MAXV = 9999;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [3:0]   num3, num2, num1, num0;
  logic         overflow;

  int           total = 0;
  int           bad   = 0;
  logic [16:0]  exp_last = '0;

  bin_to_bcd_seq #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .num3     (num3),
    .num2     (num2),
    .num1     (num1),
    .num0     (num0),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, thousands, hundreds, tens, units} by decimal arithmetic.
  function automatic logic [16:0] model(input int v);
    int s;
    logic [16:0] r;
    s        = (v > MAXV) ? MAXV : v;
    r[16]    = (v > MAXV);
    r[15:12] = 4'((s / 1000) % 10);
    r[11:8]  = 4'((s / 100) % 10);
    r[7:4]   = 4'((s / 10) % 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  function automatic logic [16:0] observed();
    return {overflow, num3, num2, num1, num0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Starts one conversion and reports the edge index of the done pulse.
  task automatic convert(input logic [W-1:0] v, output int n, output bit seen);
    bit ok;
    n    = -1;
    seen = 1'b0;
    wait_idle(ok);
    if (ok) begin
      bin   = v;
      start = 1'b1;
      step();                       // edge 0
      start = 1'b0;
      bin   = W'($urandom);         // must not disturb the running conversion
      for (int k = 1; k <= 40 && !seen; k++) begin
        step();
        if (done) begin
          seen = 1'b1;
          n    = k;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    bin     = W'(1234);
    repeat (3) step();
    total++;
    if ({busy, done, observed()} !== 19'b0)
      begin bad++; $display("FAIL reset_state got=%h want=0", {busy, done, observed()}); end
    start   = 1'b0;
    reset_n = 1'b1;
    step();
    total++;
    if (busy !== 1'b0)
      begin bad++; $display("FAIL reset_release_busy got=%b want=0", busy); end
    exp_last = '0;
  endtask

  task automatic test_zero();
    int n; bit s;
    convert(W'(0), n, s);
    total++;
    if (!s || n != 15) begin bad++; $display("FAIL zero_latency got=%0d want=15", n); end
    total++;
    if (observed() !== model(0))
      begin bad++; $display("FAIL zero_digits got=%h want=%h", observed(), model(0)); end
    exp_last = model(0);
  endtask

  task automatic test_limits();
    int vals[3] = '{9999, 12000, 5};
    int n; bit s;
    foreach (vals[i]) begin
      convert(W'(vals[i]), n, s);
      total++;
      if (!s || n != 15)
        begin bad++; $display("FAIL limit_latency v=%0d got=%0d want=15", vals[i], n); end
      total++;
      if (observed() !== model(vals[i]))
        begin bad++; $display("FAIL limit_digits v=%0d got=%h want=%h", vals[i], observed(), model(vals[i])); end
      exp_last = model(vals[i]);
    end
  endtask

  task automatic test_1234_timing();
    bit ok;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t1234_idle got=busy want=idle"); end
    bin   = W'(1234);
    start = 1'b1;
    step();                         // edge 0
    start = 1'b0;
    bin   = W'(4321);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) step();
      total++;
      if (busy !== (k <= 15))
        begin bad++; $display("FAIL t1234_busy edge=%0d got=%b want=%b", k, busy, (k <= 15)); end
      total++;
      if (done !== (k == 15))
        begin bad++; $display("FAIL t1234_done edge=%0d got=%b want=%b", k, done, (k == 15)); end
      if (k < 15) begin
        total++;
        if (observed() !== exp_last)
          begin bad++; $display("FAIL t1234_hold edge=%0d got=%h want=%h", k, observed(), exp_last); end
      end else begin
        total++;
        if (observed() !== model(1234))
          begin bad++; $display("FAIL t1234_digits edge=%0d got=%h want=%h", k, observed(), model(1234)); end
      end
    end
    exp_last = model(1234);
  endtask

  task automatic test_ignore_busy();
    bit ok;
    int pulses;
    logic [16:0] got;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ignore_idle got=busy want=idle"); end
    bin   = W'(42);
    start = 1'b1;
    step();                         // edge 0
    start  = 1'b0;
    pulses = 0;
    got    = '1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        start = 1'b1;
        bin   = W'(777);
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        pulses++;
        got = observed();
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
    total++;
    if (got !== model(42)) begin bad++; $display("FAIL ignore_digits got=%h want=%h", got, model(42)); end
    exp_last = model(42);
  endtask

  task automatic test_reset_mid();
    bit ok, s;
    int n, pulses;
    wait_idle(ok);
    bin   = W'(999);
    start = 1'b1;
    step();                         // edge 0
    start = 1'b0;
    repeat (7) step();              // edge 7
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy, done, observed()} !== 19'b0)
      begin bad++; $display("FAIL midrst_outputs got=%h want=0", {busy, done, observed()}); end
    repeat (3) step();
    reset_n = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", pulses); end
    total++;
    if (observed() !== 17'b0) begin bad++; $display("FAIL midrst_hold got=%h want=0", observed()); end
    convert(W'(808), n, s);
    total++;
    if (!s || n != 15) begin bad++; $display("FAIL midrst_808_latency got=%0d want=15", n); end
    total++;
    if (observed() !== model(808))
      begin bad++; $display("FAIL midrst_808_digits got=%h want=%h", observed(), model(808)); end
    exp_last = model(808);
  endtask

  task automatic test_hold_start();
    bit ok;
    int pulses, want_edge;
    wait_idle(ok);
    bin       = W'(321);
    start     = 1'b1;
    step();                         // edge 0
    pulses    = 0;
    want_edge = 15;
    for (int k = 1; k <= 75; k++) begin
      step();
      if (done) begin
        pulses++;
        total++;
        if (k != want_edge) begin bad++; $display("FAIL hold_edge got=%0d want=%0d", k, want_edge); end
        total++;
        if (observed() !== model(321))
          begin bad++; $display("FAIL hold_digits got=%h want=%h", observed(), model(321)); end
        want_edge += 17;
      end
    end
    start = 1'b0;
    total++;
    if (pulses != 4) begin bad++; $display("FAIL hold_pulses got=%0d want=4", pulses); end
    exp_last = model(321);
  endtask

  task automatic test_random();
    int n; bit s;
    int v;
    for (int i = 0; i < 24; i++) begin
      v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9999))
                                      : int'($urandom_range(0, (1 << W) - 1));
      convert(W'(v), n, s);
      total++;
      if (!s || n != 15) begin bad++; $display("FAIL rand_latency v=%0d got=%0d want=15", v, n); end
      total++;
      if (observed() !== model(v))
        begin bad++; $display("FAIL rand_digits v=%0d got=%h want=%h", v, observed(), model(v)); end
      exp_last = model(v);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    test_reset();
    test_zero();
    test_limits();
    test_1234_timing();
    test_ignore_busy();
    test_reset_mid();
    test_hold_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
